// File: rtl/cache_assoc_pkg.sv
// ============================================================================
// Module  : cache_assoc_pkg
// Brief   : Shared encodings for the set-associative L1 cache.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_assoc_pkg;

  typedef enum logic [2:0] {
    CACHE_IDLE       = 3'd0,
    CACHE_WRITE_BACK = 3'd1,
    CACHE_ALLOCATE   = 3'd2,
    CACHE_FLUSH_SCAN = 3'd3,
    CACHE_FLUSH_WB   = 3'd4
  } cache_state_e;

  typedef enum logic {
    CACHE_TYPE_ICACHE = 1'b0,
    CACHE_TYPE_DCACHE = 1'b1
  } cache_type_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Number of bytes touched by an access; the reserved code behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE:            return 3'd1;
      SIZE_HALF:            return 3'd2;
      SIZE_WORD, SIZE_RSVD: return 3'd4;
      default:              return 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_assoc_if.sv
// ============================================================================
// Module  : cache_assoc_if
// Brief   : Core-side and memory-side signal bundle of the L1 cache.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_assoc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16
);
  localparam int LINE_BITS = 8 * LINE_BYTES;
  localparam int OFF_W     = $clog2(LINE_BYTES);

  logic [ADDR_WIDTH-1:0]       addr_in;
  logic [31:0]                 data_in;
  logic                        read_enable_in;
  logic                        write_enable_in;
  logic [1:0]                  size_in;
  logic                        abort_in;
  logic                        flush_in;
  logic                        mem_ready_in;
  logic [LINE_BITS-1:0]        mem_data_in;
  logic [31:0]                 read_data_out;
  logic                        hit_out;
  logic                        flush_done_out;
  logic                        req_mem;
  logic                        mem_we_out;
  logic [ADDR_WIDTH-OFF_W-1:0] mem_addr_out;
  logic [LINE_BITS-1:0]        mem_data_out;

  modport master (
    output addr_in, data_in, read_enable_in, write_enable_in, size_in,
           abort_in, flush_in, mem_ready_in, mem_data_in,
    input  read_data_out, hit_out, flush_done_out, req_mem, mem_we_out,
           mem_addr_out, mem_data_out
  );

  modport slave (
    input  addr_in, data_in, read_enable_in, write_enable_in, size_in,
           abort_in, flush_in, mem_ready_in, mem_data_in,
    output read_data_out, hit_out, flush_done_out, req_mem, mem_we_out,
           mem_addr_out, mem_data_out
  );
endinterface

`default_nettype wire

// File: rtl/cache_way_select.sv
// ============================================================================
// Module  : cache_way_select
// Brief   : Tag compare and victim choice for one indexed set.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_way_select
  import cache_assoc_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int TAG_W    = 26,
  parameter int WAY_W    = 1
) (
  input  logic [NUM_WAYS-1:0]            valid_i,
  input  logic [NUM_WAYS-1:0]            dirty_i,
  input  logic [NUM_WAYS-1:0][TAG_W-1:0] tags_i,
  input  logic [TAG_W-1:0]               req_tag_i,
  input  logic [WAY_W-1:0]               rr_ptr_i,
  output logic                           hit_o,
  output logic [WAY_W-1:0]               hit_way_o,
  output logic [WAY_W-1:0]               victim_way_o,
  output logic                           victim_dirty_o
);

  logic w_found_inv;

  always_comb begin
    hit_o          = 1'b0;
    hit_way_o      = '0;
    w_found_inv    = 1'b0;
    victim_way_o   = rr_ptr_i;
    victim_dirty_o = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_i[w] && (tags_i[w] == req_tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WAY_W'(w);
      end
      if (!valid_i[w] && !w_found_inv) begin
        w_found_inv  = 1'b1;
        victim_way_o = WAY_W'(w);
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == victim_way_o) begin
        victim_dirty_o = valid_i[w] & dirty_i[w];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_assoc.sv
// ============================================================================
// Module  : cache_assoc
// Brief   : N-way set-associative write-back/write-allocate L1 cache with flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_assoc
  import cache_assoc_pkg::*;
#(
  parameter int NUM_WAYS   = 2,
  parameter int NUM_SETS   = 4,
  parameter int LINE_BYTES = 16,
  parameter int ADDR_WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  cache_assoc_if.slave bus
);

  localparam int LINE_BITS = 8 * LINE_BYTES;
  localparam int OFF_W     = $clog2(LINE_BYTES);
  localparam int IDX_W     = $clog2(NUM_SETS);
  localparam int TAG_W     = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int LADDR_W   = ADDR_WIDTH - OFF_W;
  localparam int ENTRIES   = NUM_SETS * NUM_WAYS;
  localparam int ENT_W     = $clog2(ENTRIES);

  logic [LINE_BITS-1:0]               data_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]                   tag_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  valid_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  dirty_q;
  logic [WAY_W-1:0]                   rr_q   [NUM_SETS];
  cache_state_e                       state_q;
  logic [WAY_W-1:0]                   victim_q;
  logic                               victim_rr_q;
  logic [LADDR_W-1:0]                 miss_line_q;
  logic [ENT_W-1:0]                   fl_cnt_q;
  logic                               flush_done_q;

  logic [IDX_W-1:0]                   w_set;
  logic [TAG_W-1:0]                   w_tag;
  logic [OFF_W-1:0]                   w_aoff;
  logic [2:0]                         w_nbytes;
  logic [NUM_WAYS-1:0][TAG_W-1:0]     w_set_tags;
  logic                               w_hit;
  logic [WAY_W-1:0]                   w_hit_way;
  logic [WAY_W-1:0]                   w_victim;
  logic                               w_victim_dirty;
  logic                               w_lookup_ok;
  logic                               w_req;
  logic                               w_wr_hit;
  logic                               w_miss;
  logic                               w_refill;
  logic [LINE_BITS-1:0]               w_hit_line;
  logic [LINE_BITS-1:0]               w_shifted;
  logic [LINE_BITS-1:0]               w_merge_line;
  logic [31:0]                        w_rdata;
  logic [IDX_W-1:0]                   w_fill_set;
  logic [TAG_W-1:0]                   w_fill_tag;
  logic [IDX_W-1:0]                   w_fl_set;
  logic [WAY_W-1:0]                   w_fl_way;
  logic                               w_fl_last;
  logic                               w_fl_dirty;

  assign w_set      = bus.addr_in[OFF_W +: IDX_W];
  assign w_tag      = bus.addr_in[ADDR_WIDTH-1 -: TAG_W];
  assign w_nbytes   = size_bytes(bus.size_in);
  assign w_fill_set = miss_line_q[IDX_W-1:0];
  assign w_fill_tag = miss_line_q[LADDR_W-1:IDX_W];
  assign w_fl_set   = IDX_W'(fl_cnt_q / NUM_WAYS);
  assign w_fl_way   = WAY_W'(fl_cnt_q % NUM_WAYS);
  assign w_fl_last  = (fl_cnt_q == ENT_W'(ENTRIES - 1));
  assign w_fl_dirty = valid_q[w_fl_set][w_fl_way] & dirty_q[w_fl_set][w_fl_way];

  generate
    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_tag_view
      assign w_set_tags[g] = tag_q[w_set][g];
    end
  endgenerate

  cache_way_select #(
    .NUM_WAYS (NUM_WAYS),
    .TAG_W    (TAG_W),
    .WAY_W    (WAY_W)
  ) u_way_select (
    .valid_i        (valid_q[w_set]),
    .dirty_i        (dirty_q[w_set]),
    .tags_i         (w_set_tags),
    .req_tag_i      (w_tag),
    .rr_ptr_i       (rr_q[w_set]),
    .hit_o          (w_hit),
    .hit_way_o      (w_hit_way),
    .victim_way_o   (w_victim),
    .victim_dirty_o (w_victim_dirty)
  );

  assign w_req       = bus.read_enable_in | bus.write_enable_in;
  assign w_lookup_ok = (state_q == CACHE_IDLE) & ~bus.flush_in;
  assign w_wr_hit    = w_lookup_ok & bus.write_enable_in & w_hit;
  assign w_miss      = w_lookup_ok & w_req & ~w_hit & ~bus.abort_in;
  assign w_refill    = (state_q == CACHE_ALLOCATE) & bus.mem_ready_in & ~bus.abort_in;
  assign w_hit_line  = data_q[w_set][w_hit_way];

  // Offset bits below the access size are dropped before any lane math.
  always_comb begin
    w_aoff = bus.addr_in[OFF_W-1:0];
    case (bus.size_in)
      SIZE_BYTE: ;
      SIZE_HALF: w_aoff[0]   = 1'b0;
      default:   w_aoff[1:0] = 2'b00;
    endcase
  end

  assign w_shifted = w_hit_line >> {w_aoff, 3'b000};

  always_comb begin
    case (w_nbytes)
      3'd1:    w_rdata = {24'h0, w_shifted[7:0]};
      3'd2:    w_rdata = {16'h0, w_shifted[15:0]};
      default: w_rdata = w_shifted[31:0];
    endcase
  end

  always_comb begin
    w_merge_line = w_hit_line;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(w_nbytes)) begin
        w_merge_line[(int'(w_aoff) + k) * 8 +: 8] = bus.data_in[k * 8 +: 8];
      end
    end
  end

  assign bus.hit_out        = w_lookup_ok & (~w_req | w_hit);
  assign bus.read_data_out  = (bus.hit_out & bus.read_enable_in) ? w_rdata : 32'h0;
  assign bus.flush_done_out = flush_done_q;

  always_comb begin
    bus.req_mem      = 1'b0;
    bus.mem_we_out   = 1'b0;
    bus.mem_addr_out = '0;
    bus.mem_data_out = '0;
    case (state_q)
      CACHE_WRITE_BACK: begin
        bus.req_mem      = 1'b1;
        bus.mem_we_out   = 1'b1;
        bus.mem_addr_out = {tag_q[w_fill_set][victim_q], w_fill_set};
        bus.mem_data_out = data_q[w_fill_set][victim_q];
      end
      CACHE_ALLOCATE: begin
        bus.req_mem      = ~bus.mem_ready_in;
        bus.mem_addr_out = miss_line_q;
      end
      CACHE_FLUSH_WB: begin
        bus.req_mem      = 1'b1;
        bus.mem_we_out   = 1'b1;
        bus.mem_addr_out = {tag_q[w_fl_set][w_fl_way], w_fl_set};
        bus.mem_data_out = data_q[w_fl_set][w_fl_way];
      end
      default: ;
    endcase
  end

  // Line storage carries no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      data_q[w_set][w_hit_way] <= w_merge_line;
    end
    if (w_refill) begin
      data_q[w_fill_set][victim_q] <= bus.mem_data_in;
      tag_q[w_fill_set][victim_q]  <= w_fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= CACHE_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      victim_q     <= '0;
      victim_rr_q  <= 1'b0;
      miss_line_q  <= '0;
      fl_cnt_q     <= '0;
      flush_done_q <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        CACHE_IDLE: begin
          if (bus.flush_in) begin
            fl_cnt_q <= '0;
            state_q  <= CACHE_FLUSH_SCAN;
          end else begin
            if (w_wr_hit) begin
              dirty_q[w_set][w_hit_way] <= 1'b1;
            end
            if (w_miss) begin
              victim_q    <= w_victim;
              victim_rr_q <= &valid_q[w_set];
              miss_line_q <= bus.addr_in[ADDR_WIDTH-1:OFF_W];
              state_q     <= w_victim_dirty ? CACHE_WRITE_BACK : CACHE_ALLOCATE;
            end
          end
        end
        CACHE_WRITE_BACK: begin
          if (bus.abort_in) begin
            state_q <= CACHE_IDLE;
          end else if (bus.mem_ready_in) begin
            state_q <= CACHE_ALLOCATE;
          end
        end
        CACHE_ALLOCATE: begin
          if (bus.abort_in) begin
            state_q <= CACHE_IDLE;
          end else if (bus.mem_ready_in) begin
            valid_q[w_fill_set][victim_q] <= 1'b1;
            dirty_q[w_fill_set][victim_q] <= 1'b0;
            if (victim_rr_q) begin
              rr_q[w_fill_set] <= (rr_q[w_fill_set] == WAY_W'(NUM_WAYS - 1)) ?
                                  '0 : rr_q[w_fill_set] + 1'b1;
            end
            state_q <= CACHE_IDLE;
          end
        end
        CACHE_FLUSH_SCAN, CACHE_FLUSH_WB: begin
          // A scan of a dirty entry parks in FLUSH_WB until memory accepts it.
          if ((state_q == CACHE_FLUSH_SCAN) && w_fl_dirty) begin
            state_q <= CACHE_FLUSH_WB;
          end else if ((state_q == CACHE_FLUSH_SCAN) || bus.mem_ready_in) begin
            valid_q[w_fl_set][w_fl_way] <= 1'b0;
            dirty_q[w_fl_set][w_fl_way] <= 1'b0;
            if (w_fl_last) begin
              fl_cnt_q     <= '0;
              flush_done_q <= 1'b1;
              state_q      <= CACHE_IDLE;
            end else begin
              fl_cnt_q <= fl_cnt_q + 1'b1;
              state_q  <= CACHE_FLUSH_SCAN;
            end
          end
        end
        default: state_q <= CACHE_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
